// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, common command
// bytes, the device acknowledge response and the frame length.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_INHIBIT,
    ST_RTS,
    ST_WAIT_EDGE,
    ST_WAIT_ACK,
    ST_WAIT_IDLE,
    ST_SUCCESS,
    ST_FAIL
  } ps2_tx_state_e;

  localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] PS2_CMD_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_CMD_ENABLE   = 8'hF4;
  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_RESP_ACK     = 8'hFA;

  // start + 8 data + parity + stop
  localparam int PS2_FRAME_LEN = 11;

  function automatic logic ps2_odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for the raw PS/2 clock and data pins, plus a
// registered one-cycle strobe on each falling edge of the synced clock.
// The strobe appears three clk_i cycles after the pin transition.
//
// Ports:
//   clk_i, rst_i   system clock, async active-high reset
//   ps2_clk_i      raw ps2 clock pin (asynchronous)
//   ps2_data_i     raw ps2 data pin (asynchronous)
//   clk_sync_o     synchronized clock level
//   data_sync_o    synchronized data level
//   clk_fe_o       one-cycle strobe: synced clock went 1 -> 0
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ps2_clk_i,
  input  logic ps2_data_i,
  output logic clk_sync_o,
  output logic data_sync_o,
  output logic clk_fe_o
);

  logic clk_meta_q, clk_sync_q, clk_prev_q, fe_q;
  logic data_meta_q, data_sync_q;

  // Lines idle high, so the pipeline resets to 1 to avoid a false edge
  // when reset is released with the bus idle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_meta_q  <= 1'b1;
      clk_sync_q  <= 1'b1;
      clk_prev_q  <= 1'b1;
      data_meta_q <= 1'b1;
      data_sync_q <= 1'b1;
      fe_q        <= 1'b0;
    end else begin
      clk_meta_q  <= ps2_clk_i;
      clk_sync_q  <= clk_meta_q;
      clk_prev_q  <= clk_sync_q;
      data_meta_q <= ps2_data_i;
      data_sync_q <= data_meta_q;
      fe_q        <= clk_prev_q & ~clk_sync_q;
    end
  end

  assign clk_sync_o  = clk_sync_q;
  assign data_sync_o = data_sync_q;
  assign clk_fe_o    = fe_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one command byte out on device-generated clock edges and checks
// the device acknowledge bit.
//
// Ports:
//   clk_i, rst_i     system clock, async active-high reset
//   start_i          one-cycle send request, honoured only while idle
//   data_i[7:0]      command byte, captured on an accepted start
//   busy_o           transfer in progress (through the done/err cycle)
//   done_o           one-cycle pulse: frame sent and acknowledged
//   err_o            one-cycle pulse: timeout or missing acknowledge
//   ps2_clk_i        raw ps2 clock pin level
//   ps2_data_i       raw ps2 data pin level
//   ps2_clk_oe_o     1 pulls the ps2 clock low
//   ps2_data_oe_o    1 pulls the ps2 data low
//
// state        | meaning
// ST_IDLE      | lines released, waiting for start
// ST_INHIBIT   | clock held low for INHIBIT_CYCLES
// ST_RTS       | clock low and data low (start bit), one cycle
// ST_WAIT_EDGE | clock released, drive next bit after each device edge
// ST_WAIT_ACK  | wait for edge 11, sample acknowledge on data
// ST_WAIT_IDLE | wait for device to release clock and data
// ST_SUCCESS   | done pulse
// ST_FAIL      | err pulse, lines released
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int FIRST_TIMEOUT  = 750000,
  parameter int BIT_TIMEOUT    = 100000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic [7:0] data_i,
  output logic       busy_o,
  output logic       done_o,
  output logic       err_o,
  input  logic       ps2_clk_i,
  input  logic       ps2_data_i,
  output logic       ps2_clk_oe_o,
  output logic       ps2_data_oe_o
);
  import ps2_pkg::*;

  localparam int TMR_MAX =
    (INHIBIT_CYCLES > FIRST_TIMEOUT) ?
      ((INHIBIT_CYCLES > BIT_TIMEOUT) ? INHIBIT_CYCLES : BIT_TIMEOUT) :
      ((FIRST_TIMEOUT > BIT_TIMEOUT) ? FIRST_TIMEOUT : BIT_TIMEOUT);
  localparam int TW = $clog2(TMR_MAX) + 1;

  localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] FIRST_LIM = TW'(FIRST_TIMEOUT);
  localparam logic [TW-1:0] BIT_LIM   = TW'(BIT_TIMEOUT);

  // Bits driven after device edges 1..10: data[0..7], parity, stop.
  localparam int SHIFT_LEN = PS2_FRAME_LEN - 1;
  localparam logic [3:0] STOP_IDX = 4'(SHIFT_LEN - 1);

  ps2_tx_state_e        state_q, state_d;
  logic [TW-1:0]        timer_q, timer_d;
  logic [3:0]           bit_idx_q, bit_idx_d;
  logic [SHIFT_LEN-1:0] frame_q, frame_d;
  logic                 clk_oe_q, clk_oe_d;
  logic                 data_oe_q, data_oe_d;

  logic          clk_s, data_s, clk_fe;
  logic [TW-1:0] lim, timer_inc;
  logic          timeout;

  ps2_line_sync u_sync (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .ps2_clk_i   (ps2_clk_i),
    .ps2_data_i  (ps2_data_i),
    .clk_sync_o  (clk_s),
    .data_sync_o (data_s),
    .clk_fe_o    (clk_fe)
  );

  // Timer counts cycles since the reference event (release or last edge),
  // which itself counts as cycle 0; the state leaves when it would reach lim.
  assign lim       = (state_q == ST_WAIT_EDGE && bit_idx_q == 4'd0) ? FIRST_LIM : BIT_LIM;
  assign timer_inc = (timer_q >= lim) ? timer_q : timer_q + TW'(1);
  assign timeout   = (timer_q + TW'(1)) >= lim;

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    bit_idx_d = bit_idx_q;
    frame_d   = frame_q;
    clk_oe_d  = 1'b0;
    data_oe_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          frame_d   = {1'b1, ps2_odd_parity(data_i), data_i};
          timer_d   = '0;
          bit_idx_d = '0;
          clk_oe_d  = 1'b1;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        clk_oe_d = 1'b1;
        if (timer_q == INH_LAST) begin
          data_oe_d = 1'b1;
          state_d   = ST_RTS;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_RTS: begin
        data_oe_d = 1'b1;
        timer_d   = '0;
        bit_idx_d = '0;
        state_d   = ST_WAIT_EDGE;
      end
      ST_WAIT_EDGE: begin
        data_oe_d = data_oe_q;
        if (clk_fe) begin
          data_oe_d = ~frame_q[bit_idx_q];
          bit_idx_d = bit_idx_q + 4'd1;
          timer_d   = TW'(1);
          if (bit_idx_q == STOP_IDX) state_d = ST_WAIT_ACK;
        end else if (timeout) begin
          data_oe_d = 1'b0;
          state_d   = ST_FAIL;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_WAIT_ACK: begin
        if (clk_fe) begin
          timer_d = TW'(1);
          state_d = data_s ? ST_FAIL : ST_WAIT_IDLE;
        end else if (timeout) begin
          state_d = ST_FAIL;
        end else begin
          timer_d = timer_inc;
        end
      end
      ST_WAIT_IDLE: begin
        if (clk_s && data_s)  state_d = ST_SUCCESS;
        else if (timeout)     state_d = ST_FAIL;
        else                  timer_d = timer_inc;
      end
      ST_SUCCESS, ST_FAIL: begin
        timer_d   = '0;
        bit_idx_d = '0;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      timer_q   <= '0;
      bit_idx_q <= '0;
      frame_q   <= '0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      timer_q   <= timer_d;
      bit_idx_q <= bit_idx_d;
      frame_q   <= frame_d;
      clk_oe_q  <= clk_oe_d;
      data_oe_q <= data_oe_d;
    end
  end

  assign busy_o        = (state_q != ST_IDLE);
  assign done_o        = (state_q == ST_SUCCESS);
  assign err_o         = (state_q == ST_FAIL);
  assign ps2_clk_oe_o  = clk_oe_q;
  assign ps2_data_oe_o = data_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH   = 50;
  localparam int FIRST = 2000;
  localparam int BITTO = 400;
  localparam int HP    = 40;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_i;
  logic [7:0] data_i;
  logic       busy_o, done_o, err_o;
  logic       ps2_clk_oe, ps2_data_oe;
  logic       dev_clk, dev_data;
  logic       ps2_clk_line, ps2_data_line;

  assign ps2_clk_line  = ~ps2_clk_oe & dev_clk;
  assign ps2_data_line = ~ps2_data_oe & dev_data;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .FIRST_TIMEOUT (FIRST),
    .BIT_TIMEOUT   (BITTO)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_i),
    .data_i       (data_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .err_o        (err_o),
    .ps2_clk_i    (ps2_clk_line),
    .ps2_data_i   (ps2_data_line),
    .ps2_clk_oe_o (ps2_clk_oe),
    .ps2_data_oe_o(ps2_data_oe)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int chk_total = 0;
  int chk_pass  = 0;
  int pulse_cnt = 0;
  int last_fall_cyc = -1;
  bit exp_bits[$];
  int exp_out[$];   // 1 = done, 2 = err

  typedef struct {
    logic [7:0] data;
    bit         ack_ok;
    bit         start_on_done;
    int         exp_outcome;
  } vec_t;
  vec_t vecs[5];

  task automatic check(input string name, input longint act, input longint exp);
    chk_total++;
    if (act == exp) chk_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic check_range(input string name, input longint act, input longint lo, input longint hi);
    chk_total++;
    if (act >= lo && act <= hi) chk_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  task automatic push_frame(input logic [7:0] d);
    exp_bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) exp_bits.push_back(d[i]);
    exp_bits.push_back(($countones(d) % 2 == 0) ? 1'b1 : 1'b0);
    exp_bits.push_back(1'b1);
  endtask

  task automatic sample_bit(input int idx);
    bit e;
    check($sformatf("bitq_nonempty%0d", idx), longint'(exp_bits.size() > 0), 1);
    if (exp_bits.size() > 0) begin
      e = exp_bits.pop_front();
      check($sformatf("frame_bit%0d", idx), longint'(ps2_data_line), longint'(e));
    end
  endtask

  task automatic send(input logic [7:0] d, output int s_cyc);
    @(negedge clk);
    data_i  = d;
    start_i = 1'b1;
    s_cyc   = cyc;
    @(negedge clk);
    start_i = 1'b0;
    data_i  = ~d;
    check("busy_after_start", longint'(busy_o), 1);
  endtask

  task automatic measure_inhibit();
    int c1 = -1;
    int c2 = -1;
    for (int i = 0; i < INH + 10 && c2 < 0; i++) begin
      if (c1 < 0 && ps2_clk_oe) c1 = cyc;
      if (ps2_data_oe) c2 = cyc;
      if (c2 < 0) @(negedge clk);
    end
    check("inhibit_len", longint'(c2 - c1), INH);
  endtask

  task automatic device_run(input int n_edges, input bit ack_ok);
    bit found = 1'b0;
    for (int i = 0; i < INH + 50; i++) begin
      if (!ps2_clk_oe && ps2_data_oe) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("rts_seen", longint'(found), 1);
    if (!found) return;
    repeat (HP) @(negedge clk);
    sample_bit(0);
    for (int k = 1; k <= 11; k++) begin
      if (k > n_edges) return;
      if (k == 11) begin
        dev_data = ack_ok ? 1'b0 : 1'b1;
        repeat (5) @(negedge clk);
      end
      dev_clk = 1'b0;
      last_fall_cyc = cyc;
      repeat (HP) @(negedge clk);
      dev_clk = 1'b1;
      if (k <= 10) sample_bit(k);
      repeat (HP) @(negedge clk);
    end
    dev_data = 1'b1;
  endtask

  task automatic wait_outcome(input int budget, input bit start_on_done, output int e_cyc);
    e_cyc = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_o || err_o) begin
        e_cyc = cyc;
        break;
      end
    end
    check("outcome_in_time", longint'(e_cyc >= 0), 1);
    if (start_on_done && done_o) begin
      start_i = 1'b1;
      data_i  = 8'h12;
      @(negedge clk);
      start_i = 1'b0;
      check("start_on_done_ignored", longint'(busy_o), 0);
    end
  endtask

  // Outcome scoreboard: every done/err pulse must match the next expected one.
  initial begin
    bit busy_next = 1'b0;
    int got;
    forever begin
      @(negedge clk);
      if (rst) begin
        busy_next = 1'b0;
      end else begin
        if (busy_next) begin
          check("busy_drop_after_pulse", longint'(busy_o), 0);
          busy_next = 1'b0;
        end
        if (done_o || err_o) begin
          pulse_cnt++;
          got = {30'd0, err_o, done_o};
          check("outcome_expected", longint'(exp_out.size() > 0), 1);
          if (exp_out.size() > 0) check("outcome_kind", got, exp_out.pop_front());
          if (err_o) check("lines_released_on_err", longint'({ps2_clk_oe, ps2_data_oe}), 0);
          busy_next = 1'b1;
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int s, e, p;
    vecs[0] = '{PS2_CMD_SET_LEDS, 1'b1, 1'b0, 1};
    vecs[1] = '{PS2_CMD_ENABLE,   1'b1, 1'b1, 1};
    vecs[2] = '{8'h00,            1'b1, 1'b0, 1};
    vecs[3] = '{PS2_CMD_RESET,    1'b1, 1'b0, 1};
    vecs[4] = '{PS2_CMD_ECHO,     1'b0, 1'b0, 2};

    rst = 1'b1; start_i = 1'b0; data_i = 8'h00; dev_clk = 1'b1; dev_data = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", longint'(busy_o), 0);
    check("rst_done", longint'(done_o), 0);
    check("rst_err", longint'(err_o), 0);
    check("rst_clk_oe", longint'(ps2_clk_oe), 0);
    check("rst_data_oe", longint'(ps2_data_oe), 0);

    // Reset in the middle of inhibit releases the lines asynchronously.
    send(8'hA5, s);
    repeat (10) @(negedge clk);
    check("inhibit_clk_oe", longint'(ps2_clk_oe), 1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_clk_oe", longint'(ps2_clk_oe), 0);
    check("async_rst_data_oe", longint'(ps2_data_oe), 0);
    check("async_rst_busy", longint'(busy_o), 0);
    @(negedge clk);
    rst = 1'b0;
    p = pulse_cnt;
    repeat (3 * INH) @(negedge clk);
    check("idle_after_rst_busy", longint'(busy_o), 0);
    check("idle_after_rst_pulses", longint'(pulse_cnt - p), 0);

    for (int i = 0; i < 5; i++) begin
      push_frame(vecs[i].data);
      exp_out.push_back(vecs[i].exp_outcome);
      send(vecs[i].data, s);
      measure_inhibit();
      fork
        device_run(11, vecs[i].ack_ok);
        wait_outcome(3000, vecs[i].start_on_done, e);
      join
      check($sformatf("frame_bits_consumed_v%0d", i), longint'(exp_bits.size()), 0);
      exp_bits.delete();
      repeat (5) @(negedge clk);
    end

    // Device never clocks.
    exp_out.push_back(2);
    send(8'h55, s);
    wait_outcome(INH + FIRST + 100, 1'b0, e);
    check_range("first_timeout_cycles", longint'(e - (s + 1)),
                INH + 1 + FIRST - 3, INH + 1 + FIRST + 3);
    repeat (5) @(negedge clk);

    // Device stalls after its fourth falling edge.
    push_frame(8'h96);
    exp_out.push_back(2);
    send(8'h96, s);
    measure_inhibit();
    fork
      device_run(4, 1'b1);
      wait_outcome(3000, 1'b0, e);
    join
    check("bit_timeout_cycles", longint'(e - last_fall_cyc), 3 + BITTO);
    check("partial_frame_bits_left", longint'(exp_bits.size()), 6);
    exp_bits.delete();
    repeat (5) @(negedge clk);

    // A second start during shift-out must be ignored.
    push_frame(8'h3C);
    exp_out.push_back(1);
    send(8'h3C, s);
    measure_inhibit();
    fork
      device_run(11, 1'b1);
      begin
        repeat (200) @(negedge clk);
        data_i  = 8'hFF;
        start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("busy_during_ignored_start", longint'(busy_o), 1);
      end
      wait_outcome(3000, 1'b0, e);
    join
    check("frame_bits_consumed_busy_start", longint'(exp_bits.size()), 0);
    exp_bits.delete();
    p = pulse_cnt;
    repeat (INH + FIRST + 100) @(negedge clk);
    check("no_extra_transfer_pulses", longint'(pulse_cnt - p), 0);
    check("idle_after_ignored_start", longint'(busy_o), 0);

    $display("%0d/%0d checks passed", chk_pass, chk_total);
    $finish;
  end

endmodule
